// File: rtl/rc_pulse_decoder.sv
`default_nettype none
// ============================================================================
// Module   : rc_pulse_decoder
// Purpose  : Measures one RC PWM channel in microseconds and flags loss.
//            Also derives a hysteresis- and confirm-filtered mode bit.
//            Optional failsafe forcing is enabled by RC_PULSE_DECODER_FAILSAFE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rc_pulse_decoder #(
    parameter int CLK_HZ        = 50000000,
    parameter int MIN_US        = 800,
    parameter int MAX_US        = 2200,
    parameter int THRESH_US     = 1500,
    parameter int HYST_US       = 50,
    parameter int CONFIRM       = 3,
    parameter int TIMEOUT_MS    = 50,
    parameter bit FAILSAFE_MODE = 1'b0
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        pwm_in,
    output logic [11:0] pulse_us,
    output logic        pulse_stb,
    output logic        pulse_valid,
    output logic        mode,
    output logic        signal_lost
);

`ifdef RC_PULSE_DECODER_FAILSAFE_EN
    localparam bit c_fs_en = 1'b1;
`else
    localparam bit c_fs_en = 1'b0;
`endif

    localparam int c_div     = CLK_HZ / 1000000;
    localparam int c_pre_w   = (c_div > 1) ? $clog2(c_div) : 1;
    localparam int c_limit   = TIMEOUT_MS * 1000;
    localparam int c_tmr_w   = $clog2(c_limit + 1);

    localparam logic [c_pre_w-1:0] c_pre_max  = c_pre_w'(c_div - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_max  = c_tmr_w'(c_limit);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(c_limit - 1);
    localparam logic [11:0]        c_min      = 12'(MIN_US);
    localparam logic [11:0]        c_max      = 12'(MAX_US);
    localparam logic [11:0]        c_hi       = 12'(THRESH_US + HYST_US);
    localparam logic [11:0]        c_lo       = 12'(THRESH_US - HYST_US);
    localparam logic [3:0]         c_confirm  = 4'(CONFIRM);
    localparam bit                 c_mode_rst = c_fs_en ? FAILSAFE_MODE : 1'b0;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_low  = 2'd1;
    localparam logic [1:0] c_st_high = 2'd2;

    logic               r_meta;
    logic               r_sync;
    logic               r_sync_d;
    logic [c_pre_w-1:0] r_pre;
    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [11:0]        r_width;
    logic [11:0]        w_width_inc;
    logic [c_tmr_w-1:0] r_tmr;
    logic [c_tmr_w-1:0] w_tmr_next;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_next;
    logic               w_tick;
    logic               w_rise;
    logic               w_fall;
    logic               w_start;
    logic               w_count;
    logic               w_done;
    logic               w_valid;
    logic               w_valid_stb;
    logic               w_cand;
    logic               w_lost_next;
    logic               w_mode_next;

    // Sync flops reset high so a line already high at reset never looks like a rise.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_meta   <= 1'b1;
            r_sync   <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_meta   <= pwm_in;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign w_rise = r_sync & ~r_sync_d;
    assign w_fall = ~r_sync & r_sync_d;
    assign w_tick = (r_pre == c_pre_max);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_pre <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (!r_sync) w_state_next = c_st_low;
            c_st_low:  if (w_rise)  w_state_next = c_st_high;
            c_st_high: if (w_fall)  w_state_next = c_st_low;
            default:                w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_start = (r_state == c_st_low) && w_rise;
        w_count = (r_state == c_st_high);
        w_done  = (r_state == c_st_high) && w_fall;
    end

    // The tick landing on the falling-edge cycle is included in the latched width.
    assign w_width_inc = (w_tick && (r_width != 12'hFFF)) ? r_width + 12'd1 : r_width;
    assign w_valid     = (w_width_inc >= c_min) && (w_width_inc <= c_max);
    assign w_valid_stb = w_done && w_valid;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_width <= '0;
        end else if (w_start) begin
            r_width <= '0;
        end else if (w_count) begin
            r_width <= w_width_inc;
        end
    end

    always_comb begin
        if (w_width_inc >= c_hi) begin
            w_cand = 1'b1;
        end else if (w_width_inc <= c_lo) begin
            w_cand = 1'b0;
        end else begin
            w_cand = mode;
        end
    end

    // A valid strobe outranks a coincident timeout expiry.
    always_comb begin
        w_tmr_next  = r_tmr;
        w_lost_next = signal_lost;
        if (w_valid_stb) begin
            w_tmr_next  = '0;
            w_lost_next = 1'b0;
        end else if (w_tick && (r_tmr != c_tmr_max)) begin
            w_tmr_next = r_tmr + 1'b1;
            if (r_tmr == c_tmr_last) begin
                w_lost_next = 1'b1;
            end
        end
    end

    always_comb begin
        w_mode_next = mode;
        w_cnt_next  = r_cnt;
        if (w_done) begin
            if (w_valid && (w_cand != mode)) begin
                if ((r_cnt + 4'd1) == c_confirm) begin
                    w_mode_next = ~mode;
                    w_cnt_next  = '0;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end else begin
                w_cnt_next = '0;
            end
        end
        if (c_fs_en && w_lost_next) begin
            w_mode_next = FAILSAFE_MODE;
            w_cnt_next  = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pulse_us    <= '0;
            pulse_stb   <= 1'b0;
            pulse_valid <= 1'b0;
            mode        <= c_mode_rst;
            signal_lost <= 1'b1;
            r_tmr       <= '0;
            r_cnt       <= '0;
        end else begin
            pulse_stb   <= w_done;
            if (w_done) begin
                pulse_us    <= w_width_inc;
                pulse_valid <= w_valid;
            end
            mode        <= w_mode_next;
            signal_lost <= w_lost_next;
            r_tmr       <= w_tmr_next;
            r_cnt       <= w_cnt_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rc_pulse_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rc_pulse_decoder
// Purpose  : Self-checking bench for rc_pulse_decoder: event-level model checked
//            every cycle plus directed pulse scenarios with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rc_pulse_decoder;

    localparam int c_clk_hz   = 2000000;
    localparam int c_div      = c_clk_hz / 1000000;
    localparam int c_min_us   = 800;
    localparam int c_max_us   = 2200;
    localparam int c_thresh   = 1500;
    localparam int c_hyst     = 50;
    localparam int c_confirm  = 3;
    localparam int c_tmo_ms   = 4;
    localparam int c_limit    = c_tmo_ms * 1000;
    localparam bit c_failsafe = 1'b0;
`ifdef RC_PULSE_DECODER_FAILSAFE_EN
    localparam bit c_fs_en = 1'b1;
`else
    localparam bit c_fs_en = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        pwm;
    logic [11:0] pulse_us;
    logic        pulse_stb;
    logic        pulse_valid;
    logic        mode;
    logic        signal_lost;

    rc_pulse_decoder #(
        .CLK_HZ        (c_clk_hz),
        .MIN_US        (c_min_us),
        .MAX_US        (c_max_us),
        .THRESH_US     (c_thresh),
        .HYST_US       (c_hyst),
        .CONFIRM       (c_confirm),
        .TIMEOUT_MS    (c_tmo_ms),
        .FAILSAFE_MODE (c_failsafe)
    ) dut (
        .CLOCK_50    (clk),
        .reset       (rst),
        .pwm_in      (pwm),
        .pulse_us    (pulse_us),
        .pulse_stb   (pulse_stb),
        .pulse_valid (pulse_valid),
        .mode        (mode),
        .signal_lost (signal_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state (edge n counts posedges since reset release;
    // microsecond ticks fall on every edge that is a multiple of c_div).
    int m_n, m_rise_n, m_due, m_due_w, m_us, m_cnt, m_last_valid;
    bit m_prev, m_have_rise, m_stb, m_valid, m_mode, m_lost, m_seen_valid, m_cand;

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, m_n);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_n = 0; m_prev = 1'b1; m_have_rise = 1'b0; m_due = -1; m_due_w = 0;
            m_us = 0; m_stb = 1'b0; m_valid = 1'b0; m_cnt = 0;
            m_mode = c_fs_en ? c_failsafe : 1'b0;
            m_seen_valid = 1'b0; m_last_valid = 0; m_lost = 1'b1;
        end else begin
            m_n++;
            m_stb = 1'b0;
            if (m_due == m_n) begin
                m_stb   = 1'b1;
                m_us    = m_due_w;
                m_valid = (m_due_w >= c_min_us) && (m_due_w <= c_max_us);
                if (m_valid) begin
                    m_seen_valid = 1'b1;
                    m_last_valid = m_n;
                    if (m_due_w >= c_thresh + c_hyst)      m_cand = 1'b1;
                    else if (m_due_w <= c_thresh - c_hyst) m_cand = 1'b0;
                    else                                   m_cand = m_mode;
                    if (m_cand != m_mode) begin
                        m_cnt++;
                        if (m_cnt == c_confirm) begin
                            m_mode = ~m_mode;
                            m_cnt  = 0;
                        end
                    end else begin
                        m_cnt = 0;
                    end
                end else begin
                    m_cnt = 0;
                end
            end
            // A pulse is measured from the first high sample after a real low;
            // results appear two edges after each line transition is sampled.
            if (pwm && !m_prev) begin
                m_have_rise = 1'b1;
                m_rise_n    = m_n;
            end
            if (!pwm && m_prev && m_have_rise) begin
                m_have_rise = 1'b0;
                m_due       = m_n + 2;
                m_due_w     = (m_n + 2) / c_div - (m_rise_n + 2) / c_div;
                if (m_due_w > 4095) m_due_w = 4095;
            end
            m_prev = pwm;
            m_lost = !m_seen_valid || ((m_n / c_div - m_last_valid / c_div) >= c_limit);
            if (c_fs_en && m_lost) begin
                m_mode = c_failsafe;
                m_cnt  = 0;
            end
        end
        #1;
        check("cyc_pulse_stb",   pulse_stb,   m_stb);
        check("cyc_pulse_us",    pulse_us,    m_us);
        check("cyc_pulse_valid", pulse_valid, m_valid);
        check("cyc_mode",        mode,        m_mode);
        check("cyc_signal_lost", signal_lost, m_lost);
    end

    int cap_n, cap_us, age;
    bit cap_valid, cap_mode, cap_lost;

    // Drive one high pulse of us microseconds, then low for gap_us, capturing any strobe.
    task automatic send(input int us, input int gap_us);
        pwm = 1'b1;
        repeat (us * c_div) @(negedge clk);
        pwm   = 1'b0;
        cap_n = 0;
        repeat (gap_us * c_div) begin
            @(negedge clk);
            age++;
            if (pulse_stb) begin
                cap_n++;
                cap_us    = pulse_us;
                cap_valid = pulse_valid;
                cap_mode  = mode;
                cap_lost  = signal_lost;
                age       = 0;
            end
        end
    endtask

    bit exp_hold;

    initial begin
        rst = 1'b1;
        pwm = 1'b0;
        age = 0;
        repeat (3) @(negedge clk);
        check("rst_pulse_us",    pulse_us,    0);
        check("rst_pulse_stb",   pulse_stb,   0);
        check("rst_pulse_valid", pulse_valid, 0);
        check("rst_mode",        mode,        c_fs_en ? c_failsafe : 1'b0);
        check("rst_signal_lost", signal_lost, 1);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // 1900 us pulses: mode rises on the third strobe, loss clears on the first.
        send(1900, 100);
        check("t1_p1_strobes",  cap_n, 1);
        check("t1_p1_us_range", int'(cap_us >= 1899 && cap_us <= 1900), 1);
        check("t1_p1_lost",     cap_lost, 0);
        check("t1_p1_mode",     cap_mode, 0);
        send(1900, 100);
        check("t1_p2_mode",     cap_mode, 0);
        send(1900, 100);
        check("t1_p3_mode",     cap_mode, 1);
        check("t1_p3_valid",    cap_valid, 1);

        // Inside the hysteresis band the mode holds.
        send(1460, 100);
        check("t2_1460_us",   cap_us, 1460);
        check("t2_1460_mode", cap_mode, 1);
        send(1540, 100);
        check("t2_1540_mode", cap_mode, 1);

        // Stop pulses with the line low and time the loss.
        for (int k = 0; k < 3 * c_limit * c_div && !signal_lost; k++) begin
            @(negedge clk);
            age++;
        end
        check("tmo_lost", signal_lost, 1);
        check("tmo_delay", int'(age >= c_limit * c_div - c_div + 1 && age <= c_limit * c_div), 1);
        check("tmo_mode", mode, c_fs_en ? c_failsafe : 1'b1);

        // Agreement run broken by an out-of-range pulse.
        exp_hold = c_fs_en ? c_failsafe : 1'b1;
        send(1100, 100);
        check("t3_a1_lost", cap_lost, 0);
        check("t3_a1_mode", cap_mode, exp_hold);
        send(1100, 100);
        check("t3_a2_mode", cap_mode, exp_hold);
        send(2500, 100);
        check("t3_2500_valid", cap_valid, 0);
        check("t3_2500_us",    cap_us, 2500);
        check("t3_2500_mode",  cap_mode, exp_hold);
        send(1100, 100);
        check("t3_b1_mode", cap_mode, exp_hold);
        send(1100, 100);
        check("t3_b2_mode", cap_mode, exp_hold);
        send(1100, 100);
        check("t3_b3_mode", cap_mode, 0);

        // Line stuck high for 5 ms: saturates, invalid, and the timeout fires meanwhile.
        send(5000, 100);
        check("t4_strobes", cap_n, 1);
        check("t4_us",      cap_us, 4095);
        check("t4_valid",   cap_valid, 0);
        check("t4_lost",    cap_lost, 1);

        // Reset mid-pulse, line still high at release: that pulse is never reported.
        pwm = 1'b1;
        repeat (300) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (500) @(negedge clk);
        pwm   = 1'b0;
        cap_n = 0;
        repeat (100) begin
            @(negedge clk);
            if (pulse_stb) cap_n++;
        end
        check("t5_no_strobe", cap_n, 0);
        send(1000, 100);
        check("t5_strobes", cap_n, 1);
        check("t5_us",      cap_us, 1000);
        check("t5_valid",   cap_valid, 1);
        check("t5_lost",    cap_lost, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
